// File: rtl/div_bcd_convert.sv
// Double-dabble converter: turns a divider's 16-bit quotient and remainder
// into 5-digit packed BCD, one bit per clock, fixed 32-cycle latency.
module div_bcd_convert #(
    parameter bit BLANK_LEADING = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] result,
    input  logic [15:0] odd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [19:0] result_bcd,
    output logic [19:0] odd_bcd,
    output logic [2:0]  result_ndig
);

    typedef enum logic [1:0] {IDLE, CONV_Q, CONV_R, DONE} state_t;

    state_t      state_q, state_d;
    logic [19:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] sh_q, sh_d;
    logic [15:0] rem_q, rem_d;
    logic [19:0] qbcd_q, qbcd_d;
    logic [19:0] rbcd_q, rbcd_d;
    logic [19:0] obcd_q, obcd_d;
    logic [2:0]  ndig_q, ndig_d;
    logic [19:0] step;
    logic [2:0]  qn, rn;

    function automatic logic [19:0] dd_step(logic [19:0] acc, logic bit_in);
        logic [19:0] a;
        a = acc;
        for (int i = 0; i < 5; i++) begin
            if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return {a[18:0], bit_in};
    endfunction

    function automatic logic [2:0] sig_digits(logic [19:0] b);
        logic [2:0] n;
        n = 3'd1;
        for (int i = 1; i < 5; i++) begin
            if (b[4*i +: 4] != 4'd0) n = 3'(i + 1);
        end
        return n;
    endfunction

    function automatic logic [19:0] blank(logic [19:0] b, logic [2:0] n);
        logic [19:0] r;
        r = b;
        for (int i = 1; i < 5; i++) begin
            if (i >= int'(n)) r[4*i +: 4] = 4'hF;
        end
        return r;
    endfunction

    assign step = dd_step(acc_q, sh_q[15]);
    assign qn   = sig_digits(qbcd_q);
    assign rn   = sig_digits(step);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        rem_d   = rem_q;
        qbcd_d  = qbcd_q;
        rbcd_d  = rbcd_q;
        obcd_d  = obcd_q;
        ndig_d  = ndig_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sh_d    = result;
                    rem_d   = odd;
                    acc_d   = 20'd0;
                    cnt_d   = 4'd0;
                    state_d = CONV_Q;
                end
            end
            CONV_Q: begin
                acc_d = step;
                sh_d  = {sh_q[14:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    qbcd_d  = step;
                    acc_d   = 20'd0;
                    cnt_d   = 4'd0;
                    sh_d    = rem_q;
                    state_d = CONV_R;
                end
            end
            CONV_R: begin
                acc_d = step;
                sh_d  = {sh_q[14:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    acc_d   = 20'd0;
                    cnt_d   = 4'd0;
                    rbcd_d  = BLANK_LEADING ? blank(qbcd_q, qn) : qbcd_q;
                    obcd_d  = BLANK_LEADING ? blank(step, rn) : step;
                    ndig_d  = qn;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= 20'd0;
            cnt_q   <= 4'd0;
            sh_q    <= 16'd0;
            rem_q   <= 16'd0;
            qbcd_q  <= 20'd0;
            rbcd_q  <= 20'd0;
            obcd_q  <= 20'd0;
            ndig_q  <= 3'd1;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            rem_q   <= rem_d;
            qbcd_q  <= qbcd_d;
            rbcd_q  <= rbcd_d;
            obcd_q  <= obcd_d;
            ndig_q  <= ndig_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign result_bcd  = rbcd_q;
    assign odd_bcd     = obcd_q;
    assign result_ndig = ndig_q;

endmodule

// File: doc/div_bcd_convert.md
DIV_BCD_CONVERT -- requirements
Module: div_bcd_convert

Interface
REQ-001 The parameter list SHALL be: BLANK_LEADING, default 0, meaning 1 = replace leading-zero BCD digits with 4'hF (units digit never blanked).
REQ-002 The design SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: in_valid  input  1  upstream divider result present.
REQ-006 Port: in_ready  output  1  block can accept a result.
REQ-007 Port: result  input  16  unsigned quotient from the divider stage.
REQ-008 Port: odd  input  16  unsigned remainder from the divider stage.
REQ-009 Port: out_valid  output  1  BCD results available.
REQ-010 Port: out_ready  input  1  downstream accepts BCD results.
REQ-011 Port: result_bcd  output  20  quotient as 5 packed BCD digits, [19:16] = ten-thousands.
REQ-012 Port: odd_bcd  output  20  remainder as 5 packed BCD digits.
REQ-013 Port: result_ndig  output  3  significant quotient digits, 1..5 (value 0 reports 1).

Function
REQ-014 The FSM SHALL have the states IDLE, CONV_Q, CONV_R and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-016 On a clock edge with in_valid && in_ready, the block SHALL capture result and odd, clear the BCD accumulator and 4-bit step counter, and enter CONV_Q.
REQ-017 Each CONV_Q edge SHALL perform one double-dabble step: add 3 to any accumulator digit >= 5, then shift left 1 taking the captured quotient MSB in.
REQ-018 After the 16th CONV_Q step (counter = 15), the block SHALL latch the quotient BCD, clear the accumulator and counter, and enter CONV_R.
REQ-019 CONV_R SHALL repeat the step procedure on the captured remainder for 16 edges, then latch the remainder BCD and enter DONE.
REQ-020 out_valid SHALL rise exactly 32 clock edges after the accepting edge, with no data-dependent latency.
REQ-021 result_bcd, odd_bcd and result_ndig SHALL update only on entry to DONE and SHALL stay stable while out_valid = 1.
REQ-022 The DONE -> IDLE transition SHALL occur on an edge with out_valid && out_ready; in_ready SHALL be 1 the next cycle (no same-cycle bypass).
REQ-023 Outputs SHALL keep their last values in IDLE until the next DONE entry.
REQ-024 in_valid asserted in CONV_Q, CONV_R or DONE SHALL be ignored, with no capture and no state change.
REQ-025 Input width: full 16-bit range, 0..65535; 5 digits SHALL always suffice, with no overflow condition.
REQ-026 result_ndig SHALL equal the 1-based position of the most significant nonzero digit of the quotient, or 1 if the quotient is 0.
REQ-027 With BLANK_LEADING = 1, digits above result_ndig (quotient) and above the remainder's significant digit count SHALL read 4'hF.
REQ-028 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-029 rst = 1 at a clock edge SHALL force IDLE and clear the step counter and accumulator.
REQ-030 On reset, outputs SHALL go to: out_valid = 0, result_bcd = 0, odd_bcd = 0, result_ndig = 1, and in_ready = 1 from the following cycle.
REQ-031 Reset SHALL take priority over every handshake, including a simultaneous in_valid or out_ready.
REQ-032 A reset mid-conversion SHALL abandon the conversion with no partial outputs.

Verification
REQ-033 Basic conversion SHALL be checked: result = 16'h3039 (12345), odd = 16'h0007, BLANK_LEADING = 0 -> result_bcd = 20'h12345, odd_bcd = 20'h00007, result_ndig = 5, out_valid high exactly 32 edges after accept.
REQ-034 Extremes SHALL be checked: result = 16'hFFFF, odd = 16'h0000 -> result_bcd = 20'h65535, odd_bcd = 20'h00000; then result = 0 -> result_bcd = 20'h00000, result_ndig = 1.
REQ-035 Blanking SHALL be checked: BLANK_LEADING = 1, result = 42, odd = 5 -> result_bcd = 20'hFFF42, odd_bcd = 20'hFFFF5, result_ndig = 2.
REQ-036 Backpressure SHALL be checked: out_ready = 0 for 10 cycles in DONE -> outputs constant, in_ready = 0; new in_valid pulses in that window are not captured; out_ready = 1 -> IDLE next edge.
REQ-037 Reset mid-operation SHALL be checked: rst asserted at CONV_Q step 10 -> next cycle IDLE, out_valid = 0, result_bcd = 0, in_ready = 1; a subsequent conversion of 999 yields 20'h00999.
REQ-038 Back-to-back operation SHALL be checked: in_valid held high with out_ready held high -> one result every 34 cycles (accept, 32 steps, DONE), each correct.
